// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit; both flops load RESET_VALUE on reset.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      dout <= RESET_VALUE;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, one stop bit, bit period CLKS_PER_BIT+1 clocks.
// Optional even-parity bit and uart_rx_perr port when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_ferr,
  output logic       uart_rx_busy
`ifdef UART_RX_PARITY_EN
  , output logic     uart_rx_perr
`endif
);

  localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT + 1) / 2);
  localparam logic [15:0] HALF_END = HALF - 16'd1;
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [1:0]  warm;
  logic        rxd_sync;
  logic        rxd_q;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (uart_rxd),
    .dout  (rxd_sync)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = (^shift) != par_bit;
`endif

  // warm counts the clocks until rxd_q holds a real line sample, so a line
  // that is already low when reset releases is never taken as a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      warm          <= '0;
      rxd_q         <= 1'b1;
      uart_rx_data  <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
      uart_rx_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      uart_rx_perr  <= 1'b0;
      par_bit       <= 1'b0;
`endif
    end else begin
      uart_rx_valid <= 1'b0;
      uart_rx_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      uart_rx_perr  <= 1'b0;
`endif
      rxd_q <= rxd_sync;
      if (warm != 2'd3) warm <= warm + 2'd1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (warm == 2'd3 && rxd_q && !rxd_sync) begin
            state        <= START;
            uart_rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rxd_sync) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state        <= IDLE;
              uart_rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shift[bit_idx] <= rxd_sync;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            par_bit <= rxd_sync;
            state   <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif

        // Returning to IDLE at mid stop bit lets a back-to-back start edge be seen.
        STOP: begin
          if (cnt == BIT_END) begin
            cnt          <= '0;
            state        <= IDLE;
            uart_rx_busy <= 1'b0;
            uart_rx_ferr <= !rxd_sync;
`ifdef UART_RX_PARITY_EN
            uart_rx_perr <= par_bad;
            if (rxd_sync && !par_bad) begin
`else
            if (rxd_sync) begin
`endif
              uart_rx_data  <= shift;
              uart_rx_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state        <= IDLE;
          cnt          <= '0;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame driver pushes expected pulse outcomes to a scoreboard
// queue and a negedge monitor pops and compares them whenever valid/ferr/perr pulses.
module tb_uart_rx;

  localparam int CPB      = 20;
  localparam int BIT_CLKS = CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_busy;
  logic       rx_perr;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rxd      (rxd),
    .uart_rx_data  (rx_data),
    .uart_rx_valid (rx_valid),
    .uart_rx_ferr  (rx_ferr),
    .uart_rx_busy  (rx_busy)
`ifdef UART_RX_PARITY_EN
    , .uart_rx_perr (rx_perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign rx_perr = 1'b0;
`endif

  typedef struct {
    logic       valid;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
  } vec_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic driveBit(input logic v);
    @(negedge clk);
    rxd = v;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  // Sends one frame in uart_tx timing and records the outcome the receiver must report.
  task automatic applyStimulus(input logic [7:0] data, input logic stop, input int gap, input logic par_ok);
    exp_t e;
`ifdef UART_RX_PARITY_EN
    logic par;
    par = (^data) ^ !par_ok;
    e.perr = !par_ok;
`else
    e.perr = 1'b0;
`endif
    e.valid = stop && par_ok;
    e.ferr  = !stop;
    if (e.valid) last_good = data;
    e.data = last_good;
    sb.push_back(e);

    driveBit(1'b0);
    for (int i = 0; i < 8; i++) begin
      driveBit(data[i]);
      if (i == 3) checkOutput("busy_mid_frame", rx_busy, 1);
    end
`ifdef UART_RX_PARITY_EN
    driveBit(par);
`endif
    driveBit(stop);
    repeat (gap) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_data"},  rx_data,  0);
    checkOutput({tag, "_valid"}, rx_valid, 0);
    checkOutput({tag, "_ferr"},  rx_ferr,  0);
    checkOutput({tag, "_busy"},  rx_busy,  0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rx_valid || rx_ferr || rx_perr)) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_pulse", {29'd0, rx_valid, rx_ferr, rx_perr}, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_valid", rx_valid, e.valid);
        checkOutput("pulse_ferr",  rx_ferr,  e.ferr);
        checkOutput("pulse_perr",  rx_perr,  e.perr);
        checkOutput("pulse_data",  rx_data,  e.data);
        checkOutput("busy_at_pulse", rx_busy, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   busy_cycles;

    vecs[0] = '{8'hA5, 1'b1, 30};
    vecs[1] = '{8'h00, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 30};
    vecs[3] = '{8'h11, 1'b1, 30};
    vecs[4] = '{8'h3C, 1'b0, 0};

    rxd   = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Good frames, back-to-back pair, then a framing error after a good 0x11.
    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i].data, vecs[i].stop, vecs[i].gap, 1'b1);
    waitDrain(60);

    repeat (100) @(negedge clk);
    checkOutput("low_line_no_retrigger", rx_busy, 0);
    checkOutput("data_held_after_ferr", rx_data, 8'h11);

    // Short low glitch must be rejected at the mid-start sample.
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    busy_cycles = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      rxd = (k < 5) ? 1'b0 : 1'b1;
      if (rx_busy) busy_cycles++;
    end
    checkOutput("glitch_busy_len_ok", {31'd0, (busy_cycles >= 1 && busy_cycles <= 11)}, 1);
    checkOutput("glitch_back_idle", rx_busy, 0);

    // Reset during data bit 3 of 0x5A, released while the line is low.
    driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("busy_before_reset", rx_busy, 1);
    rxd   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkResetState("midframe_reset");
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("low_release_no_start", rx_busy, 0);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 30, 1'b1);
    waitDrain(60);

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h01, 1'b1, 30, 1'b0);
    applyStimulus(8'h01, 1'b1, 30, 1'b1);
    waitDrain(60);
`endif

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
